// File: rtl/ft8_pkg.sv
// Shared FT8 (174,91) LDPC constants: code dimensions, parity-check tables and decoder state type.
// LDPC_MN is derived from LDPC_NM at elaboration so the two tables can never disagree.
package ft8_pkg;

  localparam int FT8_N = 174;
  localparam int FT8_K = 91;
  localparam int FT8_M = 83;

  // Check -> bit table, 1-based bit indices, 0 marks an unused slot.
  localparam logic [7:0] LDPC_NM [FT8_M][7] = '{
    '{8'd4,   8'd31,  8'd59,  8'd91,  8'd92,  8'd96,  8'd153},
    '{8'd5,   8'd32,  8'd60,  8'd93,  8'd115, 8'd146, 8'd0},
    '{8'd6,   8'd24,  8'd61,  8'd94,  8'd122, 8'd151, 8'd0},
    '{8'd7,   8'd33,  8'd62,  8'd95,  8'd96,  8'd143, 8'd0},
    '{8'd8,   8'd25,  8'd63,  8'd83,  8'd93,  8'd96,  8'd148},
    '{8'd6,   8'd32,  8'd64,  8'd97,  8'd126, 8'd138, 8'd0},
    '{8'd5,   8'd34,  8'd65,  8'd78,  8'd98,  8'd107, 8'd154},
    '{8'd9,   8'd35,  8'd66,  8'd99,  8'd139, 8'd146, 8'd0},
    '{8'd10,  8'd36,  8'd67,  8'd100, 8'd107, 8'd126, 8'd0},
    '{8'd11,  8'd37,  8'd67,  8'd87,  8'd101, 8'd139, 8'd158},
    '{8'd12,  8'd38,  8'd68,  8'd102, 8'd105, 8'd155, 8'd0},
    '{8'd13,  8'd39,  8'd69,  8'd103, 8'd149, 8'd162, 8'd0},
    '{8'd8,   8'd40,  8'd70,  8'd82,  8'd104, 8'd114, 8'd145},
    '{8'd14,  8'd41,  8'd71,  8'd88,  8'd102, 8'd123, 8'd156},
    '{8'd15,  8'd42,  8'd59,  8'd106, 8'd123, 8'd159, 8'd0},
    '{8'd1,   8'd33,  8'd72,  8'd106, 8'd107, 8'd157, 8'd0},
    '{8'd16,  8'd43,  8'd73,  8'd108, 8'd141, 8'd160, 8'd0},
    '{8'd17,  8'd37,  8'd74,  8'd81,  8'd109, 8'd131, 8'd154},
    '{8'd11,  8'd44,  8'd75,  8'd110, 8'd121, 8'd166, 8'd0},
    '{8'd45,  8'd55,  8'd64,  8'd111, 8'd130, 8'd161, 8'd173},
    '{8'd8,   8'd46,  8'd71,  8'd112, 8'd119, 8'd166, 8'd0},
    '{8'd18,  8'd36,  8'd76,  8'd89,  8'd113, 8'd114, 8'd143},
    '{8'd19,  8'd38,  8'd77,  8'd104, 8'd116, 8'd163, 8'd0},
    '{8'd20,  8'd47,  8'd70,  8'd92,  8'd138, 8'd165, 8'd0},
    '{8'd2,   8'd48,  8'd74,  8'd113, 8'd128, 8'd160, 8'd0},
    '{8'd21,  8'd45,  8'd78,  8'd83,  8'd117, 8'd121, 8'd151},
    '{8'd22,  8'd47,  8'd58,  8'd118, 8'd127, 8'd164, 8'd0},
    '{8'd16,  8'd39,  8'd62,  8'd112, 8'd134, 8'd158, 8'd0},
    '{8'd23,  8'd43,  8'd79,  8'd120, 8'd131, 8'd145, 8'd0},
    '{8'd19,  8'd35,  8'd59,  8'd73,  8'd110, 8'd125, 8'd161},
    '{8'd20,  8'd36,  8'd63,  8'd94,  8'd136, 8'd161, 8'd0},
    '{8'd14,  8'd31,  8'd79,  8'd98,  8'd132, 8'd164, 8'd0},
    '{8'd3,   8'd44,  8'd80,  8'd124, 8'd127, 8'd169, 8'd0},
    '{8'd19,  8'd46,  8'd81,  8'd117, 8'd135, 8'd167, 8'd0},
    '{8'd7,   8'd49,  8'd58,  8'd90,  8'd100, 8'd105, 8'd168},
    '{8'd12,  8'd50,  8'd61,  8'd118, 8'd119, 8'd144, 8'd0},
    '{8'd13,  8'd51,  8'd64,  8'd114, 8'd118, 8'd157, 8'd0},
    '{8'd24,  8'd52,  8'd76,  8'd129, 8'd148, 8'd149, 8'd0},
    '{8'd25,  8'd53,  8'd69,  8'd90,  8'd101, 8'd130, 8'd156},
    '{8'd20,  8'd46,  8'd65,  8'd80,  8'd120, 8'd140, 8'd170},
    '{8'd21,  8'd54,  8'd77,  8'd100, 8'd140, 8'd171, 8'd0},
    '{8'd35,  8'd82,  8'd133, 8'd142, 8'd171, 8'd174, 8'd0},
    '{8'd14,  8'd30,  8'd83,  8'd113, 8'd125, 8'd170, 8'd0},
    '{8'd4,   8'd29,  8'd68,  8'd120, 8'd134, 8'd173, 8'd0},
    '{8'd1,   8'd4,   8'd52,  8'd57,  8'd86,  8'd136, 8'd152},
    '{8'd26,  8'd51,  8'd56,  8'd91,  8'd122, 8'd137, 8'd168},
    '{8'd52,  8'd84,  8'd110, 8'd115, 8'd145, 8'd168, 8'd0},
    '{8'd7,   8'd50,  8'd81,  8'd99,  8'd132, 8'd173, 8'd0},
    '{8'd23,  8'd55,  8'd67,  8'd95,  8'd172, 8'd174, 8'd0},
    '{8'd26,  8'd41,  8'd77,  8'd109, 8'd141, 8'd148, 8'd0},
    '{8'd2,   8'd27,  8'd41,  8'd61,  8'd62,  8'd115, 8'd133},
    '{8'd27,  8'd40,  8'd56,  8'd124, 8'd125, 8'd126, 8'd0},
    '{8'd18,  8'd49,  8'd55,  8'd124, 8'd141, 8'd167, 8'd0},
    '{8'd6,   8'd33,  8'd85,  8'd108, 8'd116, 8'd156, 8'd0},
    '{8'd28,  8'd48,  8'd70,  8'd85,  8'd105, 8'd129, 8'd158},
    '{8'd9,   8'd54,  8'd63,  8'd131, 8'd147, 8'd155, 8'd0},
    '{8'd22,  8'd53,  8'd68,  8'd109, 8'd121, 8'd174, 8'd0},
    '{8'd3,   8'd13,  8'd48,  8'd78,  8'd95,  8'd123, 8'd0},
    '{8'd31,  8'd69,  8'd133, 8'd150, 8'd155, 8'd169, 8'd0},
    '{8'd12,  8'd43,  8'd66,  8'd89,  8'd97,  8'd135, 8'd159},
    '{8'd5,   8'd39,  8'd75,  8'd102, 8'd136, 8'd167, 8'd0},
    '{8'd2,   8'd54,  8'd86,  8'd101, 8'd135, 8'd164, 8'd0},
    '{8'd15,  8'd56,  8'd87,  8'd108, 8'd119, 8'd171, 8'd0},
    '{8'd10,  8'd44,  8'd82,  8'd91,  8'd111, 8'd144, 8'd149},
    '{8'd23,  8'd34,  8'd71,  8'd94,  8'd127, 8'd153, 8'd0},
    '{8'd11,  8'd49,  8'd88,  8'd92,  8'd142, 8'd157, 8'd0},
    '{8'd29,  8'd34,  8'd87,  8'd97,  8'd147, 8'd162, 8'd0},
    '{8'd30,  8'd50,  8'd60,  8'd86,  8'd137, 8'd142, 8'd162},
    '{8'd10,  8'd53,  8'd66,  8'd84,  8'd112, 8'd128, 8'd165},
    '{8'd22,  8'd57,  8'd85,  8'd93,  8'd140, 8'd159, 8'd0},
    '{8'd28,  8'd32,  8'd72,  8'd103, 8'd132, 8'd166, 8'd0},
    '{8'd28,  8'd29,  8'd84,  8'd88,  8'd117, 8'd143, 8'd150},
    '{8'd1,   8'd26,  8'd45,  8'd80,  8'd128, 8'd147, 8'd0},
    '{8'd17,  8'd27,  8'd89,  8'd103, 8'd116, 8'd153, 8'd0},
    '{8'd51,  8'd57,  8'd98,  8'd163, 8'd165, 8'd172, 8'd0},
    '{8'd21,  8'd37,  8'd73,  8'd138, 8'd152, 8'd169, 8'd0},
    '{8'd16,  8'd47,  8'd76,  8'd130, 8'd137, 8'd154, 8'd0},
    '{8'd3,   8'd24,  8'd30,  8'd72,  8'd104, 8'd139, 8'd0},
    '{8'd9,   8'd40,  8'd90,  8'd106, 8'd134, 8'd151, 8'd0},
    '{8'd15,  8'd58,  8'd60,  8'd74,  8'd111, 8'd150, 8'd163},
    '{8'd18,  8'd42,  8'd79,  8'd144, 8'd146, 8'd152, 8'd0},
    '{8'd25,  8'd38,  8'd65,  8'd99,  8'd122, 8'd160, 8'd0},
    '{8'd17,  8'd42,  8'd75,  8'd129, 8'd170, 8'd172, 8'd0}
  };

  // Bit -> check table, 1-based check indices; LDPC_MN[i][j] is the j-th check touching bit i.
  typedef logic [FT8_N-1:0][2:0][7:0] mn_tab_t;

  function automatic mn_tab_t build_mn();
    mn_tab_t t;
    t = '0;
    for (int c = 0; c < FT8_M; c++) begin
      for (int k = 0; k < 7; k++) begin
        int b;
        b = int'(LDPC_NM[c][k]);
        if (b != 0) begin
          if (t[b-1][0] == 8'd0) t[b-1][0] = 8'(c + 1);
          else if (t[b-1][1] == 8'd0) t[b-1][1] = 8'(c + 1);
          else t[b-1][2] = 8'(c + 1);
        end
      end
    end
    return t;
  endfunction

  localparam mn_tab_t LDPC_MN = build_mn();

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    FLIP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ldpc_syndrome.sv
// Single-cycle 83-check syndrome of a 174-bit hard-decision word, plus its Hamming weight.
module ldpc_syndrome
  import ft8_pkg::*;
(
  input  logic [FT8_N-1:0] word,
  output logic [FT8_M-1:0] syndrome,
  output logic [6:0]       weight
);

  // XOR each check's participating bits; unused table slots contribute nothing.
  always_comb begin
    syndrome = '0;
    for (int c = 0; c < FT8_M; c++) begin
      for (int k = 0; k < 7; k++) begin
        if (LDPC_NM[c][k] != 8'd0) begin
          syndrome[c] = syndrome[c] ^ word[LDPC_NM[c][k] - 8'd1];
        end else begin
          syndrome[c] = syndrome[c];
        end
      end
    end
  end

  // Count unsatisfied checks.
  always_comb begin
    weight = 7'd0;
    for (int c = 0; c < FT8_M; c++) begin
      weight = weight + {6'd0, syndrome[c]};
    end
  end

endmodule

// File: rtl/ldpc_decoder.sv
// Hard-decision bit-flip decoder for the FT8 (174,91) LDPC code.
// Alternates SYND/FLIP passes until the syndrome clears or MAX_ITER flips have been made.
module ldpc_decoder
  import ft8_pkg::*;
#(
  parameter int MAX_ITER = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FT8_N-1:0]  codeword_in,
  input  logic              codeword_valid,
  output logic              codeword_ready,
  output logic [FT8_K-1:0]  decoded_msg,
  output logic              decoded_valid,
  output logic              decoded_ok,
  output logic [5:0]        iterations,
  output logic [6:0]        parity_errors
);

  localparam logic [5:0] MAX_ITER_L = 6'(MAX_ITER);

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [FT8_N-1:0]          work_r;
  logic [FT8_M-1:0]          synd_r;
  logic [FT8_M-1:0]          synd_s;
  logic [6:0]                synd_cnt_s;
  logic [5:0]                iter_r;
  logic [FT8_N-1:0][1:0]     u_s;
  logic [1:0]                umax_s;
  logic [FT8_N-1:0]          flip_s;

  ldpc_syndrome u_synd (
    .word     (work_r),
    .syndrome (synd_s),
    .weight   (synd_cnt_s)
  );

  // Per-bit unsatisfied-check count from the latched syndrome, and its maximum.
  always_comb begin
    u_s    = '0;
    umax_s = 2'd0;
    for (int i = 0; i < FT8_N; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (LDPC_MN[i][j] != 8'd0) begin
          u_s[i] = u_s[i] + {1'b0, synd_r[7'(LDPC_MN[i][j] - 8'd1)]};
        end else begin
          u_s[i] = u_s[i];
        end
      end
      if (u_s[i] > umax_s) begin
        umax_s = u_s[i];
      end else begin
        umax_s = umax_s;
      end
    end
  end

  // Flip every bit that ties for the worst count; nothing flips when no check fails.
  always_comb begin
    flip_s = '0;
    for (int i = 0; i < FT8_N; i++) begin
      flip_s[i] = (u_s[i] == umax_s) && (umax_s != 2'd0);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (codeword_valid) state_nxt_s = SYND;
        else state_nxt_s = IDLE;
      end
      SYND: begin
        if (synd_s == '0) state_nxt_s = DONE;
        else if (iter_r >= MAX_ITER_L) state_nxt_s = DONE;
        else state_nxt_s = FLIP;
      end
      FLIP:    state_nxt_s = SYND;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else state_r <= state_nxt_s;
  end

  // Working word, latched syndrome and pass counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r <= '0;
      synd_r <= '0;
      iter_r <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (codeword_valid) begin
            work_r <= codeword_in;
            iter_r <= 6'd0;
          end
        end
        SYND: begin
          if (state_nxt_s == FLIP) synd_r <= synd_s;
        end
        FLIP: begin
          work_r <= work_r ^ flip_s;
          if (iter_r != 6'h3F) iter_r <= iter_r + 6'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Ready is registered as "next state is IDLE" so it matches state_r == IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) codeword_ready <= 1'b1;
    else codeword_ready <= (state_nxt_s == IDLE);
  end

  // Result registers load while in DONE and hold until the next DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decoded_msg   <= '0;
      decoded_valid <= 1'b0;
      decoded_ok    <= 1'b0;
      iterations    <= 6'd0;
      parity_errors <= 7'd0;
    end else if (state_r == DONE) begin
      decoded_msg   <= work_r[FT8_K-1:0];
      decoded_valid <= 1'b1;
      decoded_ok    <= (synd_cnt_s == 7'd0);
      iterations    <= iter_r;
      parity_errors <= synd_cnt_s;
    end else begin
      decoded_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ldpc_decoder.sv
// Scoreboard bench for ldpc_decoder: directed words, expectations queued at accept, checked by monitors.
module tb_ldpc_decoder;
  import ft8_pkg::*;

  typedef struct {
    logic [90:0] msg;
    logic        ok;
    logic [5:0]  iters;
    logic [6:0]  perr;
    bit          loose;
    int          lat;
    int          acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [173:0] cw, cw4;
  logic         cw_valid, cw_valid4;
  logic         rdy, rdy4, dv, dv4, ok, ok4;
  logic [90:0]  msg, msg4;
  logic [5:0]   it, it4;
  logic [6:0]   pe, pe4;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc0 = 0;
  int   n_acc4 = 0;
  exp_t q0[$];
  exp_t q4[$];
  exp_t cur0, cur4;
  logic [173:0] golden;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ldpc_decoder dut (
    .clk(clk), .rst_n(rst_n), .codeword_in(cw), .codeword_valid(cw_valid),
    .codeword_ready(rdy), .decoded_msg(msg), .decoded_valid(dv), .decoded_ok(ok),
    .iterations(it), .parity_errors(pe)
  );

  ldpc_decoder #(.MAX_ITER(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .codeword_in(cw4), .codeword_valid(cw_valid4),
    .codeword_ready(rdy4), .decoded_msg(msg4), .decoded_valid(dv4), .decoded_ok(ok4),
    .iterations(it4), .parity_errors(pe4)
  );

  task automatic cmp(string nm, logic [90:0] act, logic [90:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic check_res(string nm, exp_t e, logic [90:0] m, logic o,
                           logic [5:0] i, logic [6:0] p, int lat);
    cmp({nm, "_latency"}, 91'(lat), 91'(e.lat));
    cmp({nm, "_iterations"}, 91'(i), 91'(e.iters));
    if (e.loose) begin
      cmp({nm, "_ok_vs_perr"}, 91'(o), 91'(p == 7'd0));
      if (!o) cmp({nm, "_perr_nonzero"}, 91'(p != 7'd0), 91'(1));
    end else begin
      cmp({nm, "_msg"}, m, e.msg);
      cmp({nm, "_ok"}, 91'(o), 91'(e.ok));
      cmp({nm, "_perr"}, 91'(p), 91'(e.perr));
    end
  endtask

  // Accept observers push the expectation that was staged with the data.
  always @(posedge clk) begin
    if (rst_n && cw_valid && rdy) begin
      exp_t e;
      e = cur0;
      e.acc = cyc;
      q0.push_back(e);
      n_acc0++;
    end
  end

  always @(posedge clk) begin
    if (rst_n && cw_valid4 && rdy4) begin
      exp_t e;
      e = cur4;
      e.acc = cyc;
      q4.push_back(e);
      n_acc4++;
    end
  end

  // Monitors: compare every decoded_valid pulse against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (dv) begin
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check_res("dut", e, msg, ok, it, pe, cyc - e.acc - 1);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (dv4) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid4: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check_res("dut4", e, msg4, ok4, it4, pe4, cyc - e.acc - 1);
      end
    end
  end

  // Nonzero codeword: reduce H to RREF, pick free bits, solve the pivot bits.
  task automatic build_golden();
    logic [173:0] h [83];
    logic [173:0] tmp, x;
    int piv [83];
    bit is_piv [174];
    int r;
    r = 0;
    for (int c = 0; c < 174; c++) is_piv[c] = 1'b0;
    for (int c = 0; c < 83; c++) begin
      h[c] = '0;
      for (int k = 0; k < 7; k++)
        if (LDPC_NM[c][k] != 8'd0) h[c][LDPC_NM[c][k] - 8'd1] = 1'b1;
    end
    for (int col = 0; col < 174; col++) begin
      int p;
      p = -1;
      for (int i = r; i < 83; i++) if (p < 0 && h[i][col]) p = i;
      if (p >= 0 && r < 83) begin
        tmp = h[p]; h[p] = h[r]; h[r] = tmp;
        for (int i = 0; i < 83; i++) if (i != r && h[i][col]) h[i] = h[i] ^ h[r];
        piv[r] = col;
        is_piv[col] = 1'b1;
        r++;
      end
    end
    x = '0;
    for (int col = 0; col < 174; col++)
      if (!is_piv[col]) x[col] = (((col * 37 + 11) % 7) < 3);
    for (int i = 0; i < r; i++) x[piv[i]] = ^(h[i] & x);
    golden = x;
  endtask

  function automatic exp_t mk(logic [90:0] m, logic o, logic [5:0] i, logic [6:0] p, int lat);
    exp_t e;
    e.msg = m; e.ok = o; e.iters = i; e.perr = p; e.loose = 1'b0; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  task automatic drain(string nm);
    int n;
    n = 0;
    while ((q0.size() != 0 || q4.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q4.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d results pending, expected 0", nm, q0.size() + q4.size());
      q0.delete();
      q4.delete();
    end
    @(negedge clk);
  endtask

  task automatic send0(string nm, logic [173:0] w, exp_t e);
    int a;
    a = n_acc0;
    @(negedge clk);
    cw = w; cur0 = e; cw_valid = 1'b1;
    @(negedge clk);
    cw_valid = 1'b0;
    cmp({nm, "_accepted"}, 91'(n_acc0 - a), 91'(1));
    drain(nm);
  endtask

  initial begin
    logic [173:0] w;
    logic [90:0]  gmsg;
    int           a;
    rst_n = 1'b0; cw = '0; cw_valid = 1'b0; cw4 = '0; cw_valid4 = 1'b0;
    cur0 = mk('0, 1'b0, 6'd0, 7'd0, 0);
    cur4 = cur0;
    build_golden();
    gmsg = golden[90:0];

    repeat (3) @(posedge clk);
    #1;
    cmp("reset_ready", 91'(rdy), 91'(1));
    cmp("reset_valid", 91'(dv), 91'(0));
    cmp("reset_msg", msg, '0);
    cmp("reset_ok", 91'(ok), 91'(0));
    cmp("reset_iter", 91'(it), 91'(0));
    cmp("reset_perr", 91'(pe), 91'(0));
    @(negedge clk);
    rst_n = 1'b1;

    send0("zero", '0, mk('0, 1'b1, 6'd0, 7'd0, 2));
    send0("golden", golden, mk(gmsg, 1'b1, 6'd0, 7'd0, 2));
    w = golden; w[5] = ~w[5];
    send0("golden_bit5", w, mk(gmsg, 1'b1, 6'd1, 7'd0, 4));
    w = '0; w[5] = 1'b1;
    send0("zero_bit5", w, mk('0, 1'b1, 6'd1, 7'd0, 4));

    // Heavy error burst on the MAX_ITER=4 instance: exhausts every pass.
    w = '0;
    for (int i = 0; i < 30; i++) w[i] = 1'b1;
    a = n_acc4;
    @(negedge clk);
    cw4 = w; cur4 = mk('0, 1'b0, 6'd4, 7'd0, 10); cur4.loose = 1'b1; cw_valid4 = 1'b1;
    @(negedge clk);
    cw_valid4 = 1'b0;
    cmp("burst_accepted", 91'(n_acc4 - a), 91'(1));
    drain("burst");

    // Continuous valid: one-error words take 5 cycles, so every 5th word is taken.
    a = n_acc0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      w = (k % 2 == 1) ? golden : '0;
      w[5] = ~w[5];
      cw = w;
      cur0 = mk((k % 2 == 1) ? gmsg : 91'd0, 1'b1, 6'd1, 7'd0, 4);
      cw_valid = 1'b1;
    end
    @(negedge clk);
    cw_valid = 1'b0;
    cmp("stream_accepts", 91'(n_acc0 - a), 91'(8));
    drain("stream");

    // Reset while FLIP: decode abandoned, outputs cleared.
    w = golden; w[5] = ~w[5];
    @(negedge clk);
    cw = w; cur0 = mk(gmsg, 1'b1, 6'd1, 7'd0, 4); cw_valid = 1'b1;
    @(negedge clk);
    cw_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    q0.delete();
    #1;
    cmp("rst_mid_valid", 91'(dv), 91'(0));
    cmp("rst_mid_msg", msg, '0);
    cmp("rst_mid_ok", 91'(ok), 91'(0));
    cmp("rst_mid_iter", 91'(it), 91'(0));
    cmp("rst_mid_perr", 91'(pe), 91'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp("release_ready", 91'(rdy), 91'(1));
    repeat (8) @(negedge clk);
    send0("after_reset", golden, mk(gmsg, 1'b1, 6'd0, 7'd0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
